// File: rtl/fft_addsub_arbiter.sv
// Round-robin arbiter feeding a two-stage add / sign-select pipeline shared by
// N requesters. Results return tagged with the issuing requester index.
module fft_addsub_arbiter #(
  parameter int unsigned W = 10,
  parameter int unsigned N = 4,
  localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_valid_i,
  output logic [N-1:0]     req_ready_o,
  input  logic [N*W-1:0]   req_a_i,
  input  logic [N*W-1:0]   req_b_i,
  input  logic [N-1:0]     req_op_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [IDW-1:0]   res_id_o,
  output logic [W-1:0]     res_data_o
);

  logic [IDW-1:0] p_q, p_d;
  logic           s1_valid_q;
  logic [W-1:0]   s1_a_q, s1_b_q;
  logic           s1_op_q;
  logic [IDW-1:0] s1_id_q;
  logic           s2_valid_q;
  logic [W-1:0]   s2_data_q;
  logic [IDW-1:0] s2_id_q;

  logic           s1_load, s2_load;
  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] scan_idx;
  logic           accept;
  logic [W-1:0]   result;

  // Pipeline advance: s2 frees when empty or consumed, s1 frees when empty or moving on.
  assign s2_load = !s2_valid_q || res_ready_i;
  assign s1_load = !s1_valid_q || s2_load;

  // Rotating priority scan starting at the round-robin pointer.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (int'(p_q) + int'(k) >= int'(N)) begin
        scan_idx = IDW'(int'(p_q) + int'(k) - int'(N));
      end else begin
        scan_idx = IDW'(int'(p_q) + int'(k));
      end
      if (!win_found && req_valid_i[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  // Reset gates the grant so nothing is offered while the block is held in reset.
  assign accept = win_found && s1_load && rst_n;

  // One-hot grant to the winner when stage 1 can take it.
  always_comb begin
    req_ready_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      req_ready_o[i] = accept && (win_id == IDW'(i));
    end
  end

  // Pointer moves just past the accepted requester.
  always_comb begin
    p_d = p_q;
    if (accept) begin
      p_d = (win_id == IDW'(N - 1)) ? '0 : win_id + IDW'(1);
    end
  end

  // Arithmetic on the stage-1 operands; the two's-complement negate wraps at W bits.
  always_comb begin
    result = s1_a_q + s1_b_q;
    if (s1_op_q) begin
      if (s1_a_q == '0) begin
        result = '0;
      end else if (s1_a_q[W-1]) begin
        result = (~s1_b_q) + W'(1);
      end else begin
        result = s1_b_q;
      end
    end
  end

  // Arbitration pointer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  // Stage 1: capture the granted request's operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= 1'b0;
      s1_id_q    <= '0;
    end else if (s1_load) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_a_q  <= req_a_i[win_id*W +: W];
        s1_b_q  <= req_b_i[win_id*W +: W];
        s1_op_q <= req_op_i[win_id];
        s1_id_q <= win_id;
      end
    end
  end

  // Stage 2: hold the result and its tag until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_id_q    <= '0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q <= result;
        s2_id_q   <= s1_id_q;
      end
    end
  end

  assign res_valid_o = s2_valid_q;
  assign res_data_o  = s2_data_q;
  assign res_id_o    = s2_id_q;

endmodule

// File: tb/tb_fft_addsub_arbiter.sv
// Directed bench for fft_addsub_arbiter: reset, ops, fairness, backpressure, reset mid-flight.
module tb_fft_addsub_arbiter;
  localparam int W = 10;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   req_op = '0;
  logic           res_valid;
  logic           res_ready = 1'b1;
  logic [1:0]     res_id;
  logic [W-1:0]   res_data;

  int total = 0;
  int bad = 0;

  // Per-requester operands for the multi-requester scenarios (all op=0).
  logic [W-1:0] fa [N];
  logic [W-1:0] fb [N];

  fft_addsub_arbiter #(.W(W), .N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_op_i    (req_op),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_id_o    (res_id),
    .res_data_o  (res_data)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    req_valid = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_all_operands();
    for (int i = 0; i < N; i++) begin
      fa[i] = W'(100 * i + 5);
      fb[i] = W'(50 + i);
      req_a[i*W +: W] = fa[i];
      req_b[i*W +: W] = fb[i];
    end
    req_op = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0;
    res_ready = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (res_valid !== 1'b0 || req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL reset_hold: res_valid=%b req_ready=%b expected 0/0000", res_valid, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      total++;
      if (res_valid !== 1'b0 || req_ready !== 4'b0000 || res_data !== 10'd0) begin
        bad++;
        $display("FAIL reset_idle[%0d]: res_valid=%b req_ready=%b res_data=%h expected 0/0000/000",
                 c, res_valid, req_ready, res_data);
      end
    end
  endtask

  task automatic test_single();
    logic [W-1:0] va [2] = '{10'd300, 10'h3FF};
    logic [W-1:0] vb [2] = '{10'd900, 10'd5};
    logic         vo [2] = '{1'b0, 1'b1};
    logic [W-1:0] ve [2] = '{10'd176, 10'h3FB};
    for (int v = 0; v < 2; v++) begin
      @(negedge clk);
      req_valid = 4'b0100;
      req_a[2*W +: W] = va[v];
      req_b[2*W +: W] = vb[v];
      req_op[2] = vo[v];
      #1;
      total++;
      if (req_ready !== 4'b0100) begin
        bad++;
        $display("FAIL single_grant[%0d]: req_ready=%b expected 0100", v, req_ready);
      end
      @(negedge clk);
      req_valid = '0;
      #1;
      total++;
      if (res_valid !== 1'b0) begin
        bad++;
        $display("FAIL single_early[%0d]: res_valid=%b expected 0", v, res_valid);
      end
      @(negedge clk);
      #1;
      total++;
      if (res_valid !== 1'b1 || res_id !== 2'd2 || res_data !== ve[v]) begin
        bad++;
        $display("FAIL single_result[%0d]: valid=%b id=%0d data=%h expected 1/2/%h",
                 v, res_valid, res_id, res_data, ve[v]);
      end
    end
    @(negedge clk);
    req_op = '0;
  endtask

  task automatic test_sign_select();
    logic [W-1:0] va [3] = '{10'd0, 10'd1, 10'h200};
    logic [W-1:0] vb [3] = '{10'd7, 10'd7, 10'h200};
    logic [W-1:0] ve [3] = '{10'd0, 10'd7, 10'h200};
    for (int v = 0; v < 3; v++) begin
      @(negedge clk);
      req_valid = 4'b0010;
      req_a[1*W +: W] = va[v];
      req_b[1*W +: W] = vb[v];
      req_op[1] = 1'b1;
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      #1;
      total++;
      if (res_valid !== 1'b1 || res_id !== 2'd1 || res_data !== ve[v]) begin
        bad++;
        $display("FAIL sign_select[%0d]: valid=%b id=%0d data=%h expected 1/1/%h",
                 v, res_valid, res_id, res_data, ve[v]);
      end
    end
    @(negedge clk);
    req_op = '0;
  endtask

  task automatic test_fairness();
    int id;
    do_reset();
    res_ready = 1'b1;
    load_all_operands();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      req_valid = (k < 8) ? 4'hF : 4'h0;
      #1;
      if (k < 8) begin
        total++;
        if (req_ready !== (4'b0001 << (k % 4))) begin
          bad++;
          $display("FAIL fair_grant[%0d]: req_ready=%b expected %b", k, req_ready,
                   4'b0001 << (k % 4));
        end
      end
      total++;
      if (k >= 2) begin
        id = (k - 2) % 4;
        if (res_valid !== 1'b1 || res_id !== 2'(id) || res_data !== fa[id] + fb[id]) begin
          bad++;
          $display("FAIL fair_result[%0d]: valid=%b id=%0d data=%h expected 1/%0d/%h",
                   k, res_valid, res_id, res_data, id, fa[id] + fb[id]);
        end
      end else if (res_valid !== 1'b0) begin
        bad++;
        $display("FAIL fair_fill[%0d]: res_valid=%b expected 0", k, res_valid);
      end
    end
    @(negedge clk);
    #1;
    total++;
    if (res_valid !== 1'b0) begin
      bad++;
      $display("FAIL fair_drain: res_valid=%b expected 0", res_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_rdy [11] = '{4'h1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0};
    logic       exp_rv  [11] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int         exp_id  [11] = '{0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0};
    int id;
    load_all_operands();
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      req_valid = (k < 8) ? 4'hF : 4'h0;
      res_ready = (k >= 6);
      #1;
      total++;
      if (req_ready !== exp_rdy[k]) begin
        bad++;
        $display("FAIL bp_grant[%0d]: req_ready=%b expected %b", k, req_ready, exp_rdy[k]);
      end
      total++;
      id = exp_id[k];
      if (res_valid !== exp_rv[k] ||
          (exp_rv[k] && (res_id !== 2'(id) || res_data !== fa[id] + fb[id]))) begin
        bad++;
        $display("FAIL bp_result[%0d]: valid=%b id=%0d data=%h expected %b/%0d/%h",
                 k, res_valid, res_id, res_data, exp_rv[k], id, fa[id] + fb[id]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    load_all_operands();
    res_ready = 1'b0;
    @(negedge clk);
    req_valid = 4'hF;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (res_valid !== 1'b1 || req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL mid_full: valid=%b req_ready=%b expected 1/0000", res_valid, req_ready);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (res_valid !== 1'b0 || req_ready !== 4'b0000 || res_id !== 2'd0 || res_data !== 10'd0) begin
      bad++;
      $display("FAIL mid_reset: valid=%b req_ready=%b id=%0d data=%h expected 0/0000/0/000",
               res_valid, req_ready, res_id, res_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL mid_first_grant: req_ready=%b expected 0001", req_ready);
    end
    @(negedge clk);
    #1;
    total++;
    if (req_ready !== 4'b0010 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_second: req_ready=%b valid=%b expected 0010/0", req_ready, res_valid);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    total++;
    if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== fa[0] + fb[0]) begin
      bad++;
      $display("FAIL mid_result: valid=%b id=%0d data=%h expected 1/0/%h",
               res_valid, res_id, res_data, fa[0] + fb[0]);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_sign_select();
    test_fairness();
    test_backpressure();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
